// File: rtl/ecpri_tx.sv
// ecpri_tx: eCPRI Remote Memory Access (message type 0x04) response transmitter.
// Builds the 16-byte response header and streams it on a byte bus with a
// valid/ready handshake. Read responses append L data bytes fetched one at a
// time from local memory (read strobe, one wait cycle, then present the byte).
// A one-deep pending slot absorbs one request that arrives while busy.
module ecpri_tx #(
    parameter logic [3:0]  ECPRI_REV  = 4'h1,
    parameter logic [15:0] ELEMENT_ID = 16'h0000,
    parameter int          MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_write_resp,
    input  logic                  send_read_resp,
    input  logic [7:0]            info_to_tx,
    input  logic [7:0]            tx_payload_len,
    input  logic [MEM_ADDR_W-1:0] rd_base_addr,
    output logic                  mem_rd_en,
    output logic [MEM_ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]            mem_rd_data,
    output logic [7:0]            tx_buff,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic                  busy,
    output logic                  req_overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DATA    = 3'd4
    } state_t;

    typedef struct packed {
        logic                  is_read;
        logic [7:0]            id;
        logic [7:0]            len;
        logic [MEM_ADDR_W-1:0] addr;
    } req_t;

    state_t                state_reg;
    req_t                  cur_reg;
    req_t                  pend_reg;
    logic                  pend_valid_reg;
    logic [4:0]            cnt_reg;
    logic [7:0]            idx_reg;
    logic [7:0]            tx_buff_reg;
    logic                  tx_valid_reg;
    logic                  tx_sop_reg;
    logic                  tx_eop_reg;
    logic                  mem_rd_en_reg;
    logic [MEM_ADDR_W-1:0] mem_rd_addr_reg;
    logic                  overflow_reg;

    // Arbitration results for this cycle
    req_t                  cand [3];
    logic                  cand_v [3];
    logic                  avail;
    logic                  start_go;
    req_t                  start_req;
    logic                  pend_valid_next;
    req_t                  pend_next;
    logic                  overflow_set;

    logic                  accept;
    logic                  eop_accept;
    logic                  hdr_only;

    assign accept     = tx_valid_reg & tx_ready;
    assign eop_accept = accept & tx_eop_reg;
    // Write responses and zero-length reads end with the header.
    assign hdr_only   = !cur_reg.is_read || (cur_reg.len == 8'd0);

    // Header byte n of the frame described by r.
    function automatic logic [7:0] hdr_byte(input logic [3:0] n, input req_t r);
        logic [15:0] size;
        logic [47:0] a48;
        logic [7:0]  b;
        size = 16'd12 + (r.is_read ? {8'h00, r.len} : 16'h0000);
        a48  = 48'(r.addr);
        case (n)
            4'd0:    b = {ECPRI_REV, 4'h0};
            4'd1:    b = 8'h04;
            4'd2:    b = size[15:8];
            4'd3:    b = size[7:0];
            4'd4:    b = r.id;
            4'd5:    b = r.is_read ? 8'h01 : 8'h11;
            4'd6:    b = ELEMENT_ID[15:8];
            4'd7:    b = ELEMENT_ID[7:0];
            4'd8:    b = a48[47:40];
            4'd9:    b = a48[39:32];
            4'd10:   b = a48[31:24];
            4'd11:   b = a48[23:16];
            4'd12:   b = a48[15:8];
            4'd13:   b = a48[7:0];
            4'd14:   b = 8'h00;
            default: b = r.len;
        endcase
        return b;
    endfunction

    // Request arbitration: pending slot first, then read, then write; when a
    // frame can start the first candidate starts, the next fills the slot and
    // anything left is dropped as overflow.
    always_comb begin
        avail           = (state_reg == IDLE) || eop_accept;
        cand[0]         = pend_reg;
        cand_v[0]       = pend_valid_reg && avail;
        cand[1]         = '{is_read: 1'b1, id: info_to_tx, len: tx_payload_len, addr: rd_base_addr};
        cand_v[1]       = send_read_resp;
        cand[2]         = '{is_read: 1'b0, id: info_to_tx, len: tx_payload_len, addr: rd_base_addr};
        cand_v[2]       = send_write_resp;
        start_go        = 1'b0;
        start_req       = '0;
        pend_valid_next = avail ? 1'b0 : pend_valid_reg;
        pend_next       = pend_reg;
        overflow_set    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (cand_v[i]) begin
                if (avail && !start_go) begin
                    start_go  = 1'b1;
                    start_req = cand[i];
                end else if (!pend_valid_next) begin
                    pend_valid_next = 1'b1;
                    pend_next       = cand[i];
                end else begin
                    overflow_set = 1'b1;
                end
            end
        end
    end

    // Frame FSM with registered byte-bus and memory-read outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cur_reg         <= '0;
            pend_reg        <= '0;
            pend_valid_reg  <= 1'b0;
            cnt_reg         <= 5'd0;
            idx_reg         <= 8'd0;
            tx_buff_reg     <= 8'd0;
            tx_valid_reg    <= 1'b0;
            tx_sop_reg      <= 1'b0;
            tx_eop_reg      <= 1'b0;
            mem_rd_en_reg   <= 1'b0;
            mem_rd_addr_reg <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            pend_valid_reg <= pend_valid_next;
            pend_reg       <= pend_next;
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    // frame start is handled below
                end
                HDR: begin
                    if (accept) begin
                        tx_sop_reg <= 1'b0;
                        if (cnt_reg == 5'd15) begin
                            tx_valid_reg <= 1'b0;
                            tx_eop_reg   <= 1'b0;
                            if (tx_eop_reg) begin
                                state_reg <= IDLE;
                            end else begin
                                mem_rd_en_reg   <= 1'b1;
                                mem_rd_addr_reg <= cur_reg.addr;
                                state_reg       <= RD_REQ;
                            end
                        end else begin
                            cnt_reg     <= cnt_reg + 5'd1;
                            tx_buff_reg <= hdr_byte(4'(cnt_reg + 5'd1), cur_reg);
                            tx_eop_reg  <= (cnt_reg == 5'd14) && hdr_only;
                        end
                    end
                end
                RD_REQ: begin
                    mem_rd_en_reg <= 1'b0;
                    state_reg     <= RD_WAIT;
                end
                RD_WAIT: begin
                    tx_buff_reg  <= mem_rd_data;
                    tx_valid_reg <= 1'b1;
                    tx_eop_reg   <= (idx_reg == 8'(cur_reg.len - 8'd1));
                    state_reg    <= DATA;
                end
                DATA: begin
                    if (accept) begin
                        tx_valid_reg <= 1'b0;
                        tx_eop_reg   <= 1'b0;
                        if (tx_eop_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg         <= idx_reg + 8'd1;
                            mem_rd_en_reg   <= 1'b1;
                            mem_rd_addr_reg <= cur_reg.addr + MEM_ADDR_W'(idx_reg + 8'd1);
                            state_reg       <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            // A new frame starts from IDLE or directly after the eop byte is taken.
            if (start_go) begin
                cur_reg      <= start_req;
                state_reg    <= HDR;
                cnt_reg      <= 5'd0;
                idx_reg      <= 8'd0;
                tx_valid_reg <= 1'b1;
                tx_sop_reg   <= 1'b1;
                tx_eop_reg   <= 1'b0;
                tx_buff_reg  <= hdr_byte(4'd0, start_req);
            end
        end
    end

    assign tx_buff      = tx_buff_reg;
    assign tx_valid     = tx_valid_reg;
    assign tx_sop       = tx_sop_reg;
    assign tx_eop       = tx_eop_reg;
    assign mem_rd_en    = mem_rd_en_reg;
    assign mem_rd_addr  = mem_rd_addr_reg;
    assign req_overflow = overflow_reg;
    assign busy         = (state_reg != IDLE) || pend_valid_reg;

endmodule

// File: tb/tb_ecpri_tx.sv
// Scoreboard bench for ecpri_tx: stimulus pushes hand-computed frame bytes
// into a queue; a negedge monitor pops and compares every accepted byte and
// checks that outputs hold while the sink stalls.
module tb_ecpri_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_write_resp;
    logic       send_read_resp;
    logic [7:0] info_to_tx;
    logic [7:0] tx_payload_len;
    logic [7:0] rd_base_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic [7:0] tx_buff;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop;
    logic       tx_eop;
    logic       busy;
    logic       req_overflow;

    always #5 clk = ~clk;

    ecpri_tx #(.ECPRI_REV(4'h1), .ELEMENT_ID(16'h0000), .MEM_ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .send_write_resp(send_write_resp), .send_read_resp(send_read_resp),
        .info_to_tx(info_to_tx), .tx_payload_len(tx_payload_len), .rd_base_addr(rd_base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .tx_buff(tx_buff), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy), .req_overflow(req_overflow)
    );

    // Local memory model with one-cycle registered read
    logic [7:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    typedef struct packed {
        logic [7:0] b;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   frame_pos = 0;
    int   frames = 0;
    int   rd_en_cnt = 0;
    bit   b2b_mode = 0;
    bit   b2b_pending = 0;
    bit   prev_stall = 0;
    logic [9:0] prev_word = '0;

    logic [7:0] h_t1  [16] = '{8'h10,8'h04,8'h00,8'h0C,8'h5A,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h20,8'h00,8'h04};
    logic [7:0] h_t2  [16] = '{8'h10,8'h04,8'h00,8'h0F,8'h03,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFE,8'h00,8'h03};
    logic [7:0] h_t4r [16] = '{8'h10,8'h04,8'h00,8'h0E,8'h11,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFE,8'h00,8'h02};
    logic [7:0] h_t4w [16] = '{8'h10,8'h04,8'h00,8'h0C,8'h11,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFE,8'h00,8'h02};
    logic [7:0] h_t5a [16] = '{8'h10,8'h04,8'h00,8'h0C,8'h07,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h12,8'h00,8'h00};
    logic [7:0] h_t5b [16] = '{8'h10,8'h04,8'h01,8'h0B,8'h08,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h10,8'h00,8'hFF};
    logic [7:0] h_t6a [16] = '{8'h10,8'h04,8'h00,8'h0C,8'h44,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h33,8'h00,8'h02};
    logic [7:0] h_t6b [16] = '{8'h10,8'h04,8'h00,8'h0C,8'h55,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h01,8'h00,8'h01};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic sop, input logic eop);
        exp_t e;
        e.b = b; e.sop = sop; e.eop = eop;
        expq.push_back(e);
    endtask

    task automatic push_hdr(input logic [7:0] h [16], input bit ends);
        for (int i = 0; i < 16; i++) push_byte(h[i], i == 0, ends && (i == 15));
    endtask

    task automatic pulse(input logic rd, input logic wr, input logic [7:0] id,
                         input logic [7:0] len, input logic [7:0] addr);
        @(posedge clk); #1;
        send_read_resp = rd; send_write_resp = wr;
        info_to_tx = id; tx_payload_len = len; rd_base_addr = addr;
        @(posedge clk); #1;
        send_read_resp = 1'b0; send_write_resp = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < max), 32'd1);
    endtask

    // Monitor: compare each accepted byte and check stability under stall
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall  = 0;
            b2b_pending = 0;
        end else begin
            if (mem_rd_en) rd_en_cnt++;
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_hold", 32'({tx_buff, tx_sop, tx_eop}), 32'(prev_word));
            end
            if (b2b_pending) begin
                check("b2b_sop", 32'({tx_valid, tx_sop}), 32'd3);
                b2b_pending = 0;
            end
            if (tx_valid && tx_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got 0x%0h sop=%0d eop=%0d, expected no byte", tx_buff, tx_sop, tx_eop);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("f%0d_b%0d_data", frames, frame_pos), 32'(tx_buff), 32'(e.b));
                    check($sformatf("f%0d_b%0d_sop", frames, frame_pos), 32'(tx_sop), 32'(e.sop));
                    check($sformatf("f%0d_b%0d_eop", frames, frame_pos), 32'(tx_eop), 32'(e.eop));
                    frame_pos++;
                    if (tx_eop) begin
                        $display("frame %0d complete: %0d bytes", frames, frame_pos);
                        frames++;
                        frame_pos = 0;
                        if (b2b_mode && expq.size() > 0) b2b_pending = 1;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_word  = {tx_buff, tx_sop, tx_eop};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'hFE] = 8'hAA;
        mem[8'hFF] = 8'hBB;
        mem[8'h00] = 8'hCC;

        reset = 1'b1;
        send_write_resp = 1'b0; send_read_resp = 1'b0;
        info_to_tx = 8'h00; tx_payload_len = 8'h00; rd_base_addr = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_sop_eop", 32'({tx_sop, tx_eop}), 32'd0);
        check("rst_tx_buff", 32'(tx_buff), 32'd0);
        check("rst_mem_rd", 32'({mem_rd_en, mem_rd_addr}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(req_overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: write response
        push_hdr(h_t1, 1);
        pulse(1'b0, 1'b1, 8'h5A, 8'h04, 8'h20);
        wait_done(200, "t1");

        // 2: read response, address wraps FF -> 00
        push_hdr(h_t2, 0);
        push_byte(8'hAA, 0, 0); push_byte(8'hBB, 0, 0); push_byte(8'hCC, 0, 1);
        pulse(1'b1, 1'b0, 8'h03, 8'h03, 8'hFE);
        wait_done(200, "t2");

        // 3: same read with ready toggling and a 5-cycle stall mid-header
        push_hdr(h_t2, 0);
        push_byte(8'hAA, 0, 0); push_byte(8'hBB, 0, 0); push_byte(8'hCC, 0, 1);
        pulse(1'b1, 1'b0, 8'h03, 8'h03, 8'hFE);
        c = 0;
        while ((expq.size() != 0 || busy) && c < 400) begin
            @(posedge clk); #1;
            tx_ready = (c >= 4 && c < 9) ? 1'b0 : ((c % 2) == 0);
            c++;
        end
        tx_ready = 1'b1;
        check("t3_timeout", 32'(c < 400), 32'd1);

        // 4: read+write together, third request dropped
        @(negedge clk);
        check("t4_ovf_before", 32'(req_overflow), 32'd0);
        b2b_mode = 1;
        push_hdr(h_t4r, 0);
        push_byte(8'hAA, 0, 0); push_byte(8'hBB, 0, 1);
        push_hdr(h_t4w, 1);
        pulse(1'b1, 1'b1, 8'h11, 8'h02, 8'hFE);
        @(negedge clk);
        check("t4_busy_pending", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        pulse(1'b0, 1'b1, 8'h33, 8'h01, 8'h40);
        @(negedge clk);
        check("t4_ovf_after", 32'(req_overflow), 32'd1);
        wait_done(300, "t4");
        b2b_mode = 0;

        // 5a: zero-length read, no memory access
        rd_en_cnt = 0;
        push_hdr(h_t5a, 1);
        pulse(1'b1, 1'b0, 8'h07, 8'h00, 8'h12);
        wait_done(200, "t5a");
        check("t5a_rd_en_count", 32'(rd_en_cnt), 32'd0);

        // 5b: maximum-length read, 271 bytes
        rd_en_cnt = 0;
        push_hdr(h_t5b, 0);
        for (int i = 0; i < 255; i++) push_byte(mem[8'(8'h10 + i)], 0, i == 254);
        pulse(1'b1, 1'b0, 8'h08, 8'hFF, 8'h10);
        wait_done(2000, "t5b");
        check("t5b_rd_en_count", 32'(rd_en_cnt), 32'd255);

        // 6: reset while header byte 7 is on the bus
        push_hdr(h_t6a, 1);
        pulse(1'b0, 1'b1, 8'h44, 8'h02, 8'h33);
        n = 0;
        while (frame_pos < 7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_reach_b7", 32'(n < 100), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete();
        frame_pos = 0;
        @(negedge clk);
        check("t6_valid_after_rst", 32'(tx_valid), 32'd0);
        check("t6_eop_after_rst", 32'(tx_eop), 32'd0);
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        check("t6_ovf_after_rst", 32'(req_overflow), 32'd0);
        push_hdr(h_t6b, 1);
        pulse(1'b0, 1'b1, 8'h55, 8'h01, 8'h01);
        wait_done(200, "t6b");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
